joy_turbo: RTL
==============

Name: joy_turbo

Overview:
- Conditions raw host joystick words for up to four Genesis pads before they reach the multitap/port I/O stage.
- Per player it does three things:
  - resolves simultaneous opposite directions (SOCD);
  - applies frame-locked autofire to selected face buttons;
  - registers the result as a clean 12-bit button vector.
- Its outputs feed the P1..P4 button inputs of the multitap stage directly.

Parameters:
- NPLAYERS, 4, number of player lanes instantiated (1..4); unused output lanes tie to 0.

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- VBLANK  in  1  video vertical blank level; its rising edge is the frame tick.
- SOCD_MODE  in  2  0=pass, 1=neutral both axes, 2=last-input-wins both axes, 3=L+R neutral / U+D resolves to UP.
- TURBO_RATE  in  2  autofire half-period in frames = TURBO_RATE+1.
- JOY1..JOY4  in  12 each  raw buttons, active-high. Bit map: [0]RIGHT [1]LEFT [2]DOWN [3]UP [4]A [5]B [6]C [7]START [8]MODE [9]X [10]Y [11]Z.
- TURBO1..TURBO4  in  6 each  autofire enable per button. Bit map: [0]A [1]B [2]C [3]X [4]Y [5]Z.
- P1_OUT..P4_OUT  out  12 each  conditioned buttons, same bit map as JOYn, active-high, registered.

Behaviour:
- **Reset (RESET_N low, async):**
  - all Pn_OUT = 0;
  - frame counters = 0, phase = 1, axis-history = NONE, vblank_d = 0.
  - Reset asserted mid-press clears everything immediately; after release, outputs follow inputs on the next clock edge.
- **Frame tick:** tick = VBLANK & ~vblank_d (vblank_d registered each CLK). Exactly one tick per VBLANK rising edge, regardless of its width.
- **Output latency:** Pn_OUT <= f(JOYn, SOCD state, phase) on every CLK, i.e. 1 cycle from JOYn change. START, MODE and non-turbo face buttons pass through with that 1-cycle latency.
- **Autofire, per player lane:**
  - held = |(TURBOn & JOYn face bits).
  - held=0: cnt <= 0, phase <= 1.
  - held=1 and tick:
    - if cnt == TURBO_RATE: cnt <= 0, phase <= ~phase;
    - else cnt <= cnt+1.
  - A turbo-enabled button outputs JOY bit & phase; a non-enabled button outputs the JOY bit.
  - New press (held 0->1) is seen as pressed on the first output cycle, because phase is 1.
  - Phase flips at the tick-cycle edge, so the output reflects the flip 2 cycles after VBLANK rises.
  - Frequency at 60 Hz and rate r = 30/(r+1) Hz.
  - TURBO_RATE changed mid-hold: takes effect at the next compare. If cnt > new rate, cnt wraps through 7 and no glitch beyond one long half-period occurs.
  - cnt width is 3 bits.
- **SOCD, per axis** (LR uses bits 1/0, UD uses bits 3/2):
  - hist in {NONE, NEG, POS}, where NEG = LEFT/UP and POS = RIGHT/DOWN.
  - hist updates every cycle from JOYn and the previous JOYn (jprev):
    - only NEG newly pressed -> NEG;
    - only POS newly pressed -> POS;
    - both newly pressed in the same cycle -> NONE;
    - neither held -> NONE;
    - otherwise hold.
  - Mode 0: both bits passed.
  - Mode 1: both held -> both 0.
  - Mode 2: both held -> the side in hist output; hist=NONE -> both 0. One held -> that one.
  - Mode 3: LR as mode 1; UD both held -> UP only.
  - SOCD_MODE change takes effect on the next output cycle. hist is maintained in all modes so that switching into mode 2 is immediately correct.
- **Ordering:** SOCD applies only to direction bits and autofire only to face bits; the two are independent and both resolve in the same cycle.
- **Lanes:** no state is shared between players except vblank_d/tick.

Test Plan:
1. Reset with JOY1=0xFFF held: P1_OUT=0 during reset; 1 cycle after RESET_N rises P1_OUT=0xFFF (SOCD_MODE=0, TURBO1=0).
2. SOCD_MODE=1, JOY1=0x003 (L+R): P1_OUT=0x000. Same stimulus with mode 3, JOY1=0x00C (U+D): P1_OUT=0x008.
3. SOCD_MODE=2: press RIGHT (0x001), then 5 cycles later add LEFT (0x003) -> P1_OUT=0x002. Release LEFT -> 0x001. Then press L and R in the same cycle from 0 -> 0x000.
4. TURBO2=0x01, TURBO_RATE=1, JOY2=0x010 held over 8 VBLANK pulses: P2_OUT[4] pattern per frame 1,1,0,0,1,1,0,0. Each transition occurs 2 cycles after a VBLANK rise; B held simultaneously stays 1 throughout.
5. Turbo mid-hold: release A mid low-phase, re-press -> P1_OUT[4]=1 on the next cycle (phase restored to 1, cnt=0).
6. Wide VBLANK (held high for 1000 cycles) produces exactly one phase step. Assert RESET_N low during turbo -> outputs 0 asynchronously, cnt/phase restart.

Source files
------------

// File: rtl/joy_turbo.sv
// joy_turbo: per-player SOCD resolution and frame-locked autofire for up to
// four Genesis pads, registered as 12-bit button vectors for the multitap stage.
`default_nettype none
`timescale 1ns/1ps

module joy_turbo #(
  parameter int NPLAYERS = 4
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        VBLANK,
  input  logic [1:0]  SOCD_MODE,
  input  logic [1:0]  TURBO_RATE,
  input  logic [11:0] JOY1,
  input  logic [11:0] JOY2,
  input  logic [11:0] JOY3,
  input  logic [11:0] JOY4,
  input  logic [5:0]  TURBO1,
  input  logic [5:0]  TURBO2,
  input  logic [5:0]  TURBO3,
  input  logic [5:0]  TURBO4,
  output logic [11:0] P1_OUT,
  output logic [11:0] P2_OUT,
  output logic [11:0] P3_OUT,
  output logic [11:0] P4_OUT
);

  localparam logic [1:0] HIST_NONE = 2'd0;
  localparam logic [1:0] HIST_NEG  = 2'd1;
  localparam logic [1:0] HIST_POS  = 2'd2;

  logic        vblank_q;
  logic        w_tick;
  logic [11:0] w_joy [4];
  logic [5:0]  w_turbo [4];
  logic [11:0] w_out [4];

  assign w_tick = VBLANK & ~vblank_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) vblank_q <= 1'b0;
    else          vblank_q <= VBLANK;
  end

  assign w_joy[0]   = JOY1;
  assign w_joy[1]   = JOY2;
  assign w_joy[2]   = JOY3;
  assign w_joy[3]   = JOY4;
  assign w_turbo[0] = TURBO1;
  assign w_turbo[1] = TURBO2;
  assign w_turbo[2] = TURBO3;
  assign w_turbo[3] = TURBO4;
  assign P1_OUT     = w_out[0];
  assign P2_OUT     = w_out[1];
  assign P3_OUT     = w_out[2];
  assign P4_OUT     = w_out[3];

  // Last-press history for one axis; both pressed at once leaves no winner.
  function automatic logic [1:0] hist_next(input logic neg, input logic pos,
                                           input logic pneg, input logic ppos,
                                           input logic [1:0] hist);
    logic neg_new;
    logic pos_new;
    neg_new = neg & ~pneg;
    pos_new = pos & ~ppos;
    if (neg_new && pos_new)  hist_next = HIST_NONE;
    else if (neg_new)        hist_next = HIST_NEG;
    else if (pos_new)        hist_next = HIST_POS;
    else if (!neg && !pos)   hist_next = HIST_NONE;
    else                     hist_next = hist;
  endfunction

  // Returns {neg, pos} after resolving opposite directions on one axis.
  function automatic logic [1:0] socd(input logic neg, input logic pos,
                                      input logic [1:0] mode,
                                      input logic [1:0] hist, input logic is_ud);
    socd = {neg, pos};
    if (neg && pos) begin
      case (mode)
        2'd1:    socd = 2'b00;
        2'd2:    socd = (hist == HIST_NEG) ? 2'b10 :
                        (hist == HIST_POS) ? 2'b01 : 2'b00;
        2'd3:    socd = is_ud ? 2'b10 : 2'b00;
        default: socd = 2'b11;
      endcase
    end
  endfunction

  for (genvar i = 0; i < 4; i++) begin : g_lane
    if (i < NPLAYERS) begin : g_active
      logic [3:0]  jprev_q;
      logic [1:0]  hlr_q, hlr_d, hud_q, hud_d;
      logic [2:0]  cnt_q, cnt_d;
      logic        phase_q, phase_d;
      logic [11:0] out_q, out_d;
      logic [11:0] w_tmask;
      logic        w_held;

      // Turbo enables mapped onto the JOY bit positions of A,B,C,X,Y,Z.
      assign w_tmask = {w_turbo[i][5:3], 2'b00, w_turbo[i][2:0], 4'b0000};
      assign w_held  = |(w_tmask & w_joy[i]);

      always_comb begin
        hlr_d   = hist_next(w_joy[i][1], w_joy[i][0], jprev_q[1], jprev_q[0], hlr_q);
        hud_d   = hist_next(w_joy[i][3], w_joy[i][2], jprev_q[3], jprev_q[2], hud_q);
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!w_held) begin
          cnt_d   = 3'd0;
          phase_d = 1'b1;
        end else if (w_tick) begin
          if (cnt_q == {1'b0, TURBO_RATE}) begin
            cnt_d   = 3'd0;
            phase_d = ~phase_q;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        out_d      = w_joy[i] & ~(w_tmask & {12{~phase_q}});
        out_d[1:0] = socd(w_joy[i][1], w_joy[i][0], SOCD_MODE, hlr_d, 1'b0);
        out_d[3:2] = socd(w_joy[i][3], w_joy[i][2], SOCD_MODE, hud_d, 1'b1);
      end

      always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
          jprev_q <= 4'd0;
          hlr_q   <= HIST_NONE;
          hud_q   <= HIST_NONE;
          cnt_q   <= 3'd0;
          phase_q <= 1'b1;
          out_q   <= 12'd0;
        end else begin
          jprev_q <= w_joy[i][3:0];
          hlr_q   <= hlr_d;
          hud_q   <= hud_d;
          cnt_q   <= cnt_d;
          phase_q <= phase_d;
          out_q   <= out_d;
        end
      end

      assign w_out[i] = out_q;
    end else begin : g_unused
      assign w_out[i] = 12'd0;
    end
  end

endmodule

`default_nettype wire
